// File: rtl/sparce_sasa_table.sv
// Sparsity-aware skip address table: a memory-mapped two-word write port programs
// direct-mapped skip descriptors, and fetch PCs look them up with one cycle of latency.
module sparce_sasa_table #(
    parameter int          SASA_ENTRIES = 16,
    parameter logic [31:0] SASA_ADDR    = 32'h0000_1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc,
    input  logic        if_ex_enable,
    input  logic [31:0] sasa_addr,
    input  logic [31:0] sasa_data,
    input  logic        sasa_wen,
    output logic        hit,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  insts,
    output logic        cond,
    output logic        wr_pending
);

    localparam int IDX   = $clog2(SASA_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic {
        IDLE,
        HAVE_PC
    } wr_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       insts;
        logic             cond;
    } entry_t;

    wr_state_t               state_q;
    logic [29:0]             pc_q;
    logic [SASA_ENTRIES-1:0] valid_q;
    entry_t                  table_q [SASA_ENTRIES];

    logic             wr_word0;
    logic             wr_word1;
    logic             wr_clear;
    logic             commit;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    entry_t           lk_entry;

    assign wr_word0 = sasa_wen && (sasa_addr == SASA_ADDR);
    assign wr_word1 = sasa_wen && (sasa_addr == SASA_ADDR + 32'd4);
    assign wr_clear = sasa_wen && (sasa_addr == SASA_ADDR + 32'd8);
    assign commit   = wr_word1 && (state_q == HAVE_PC);

    assign wr_idx   = pc_q[IDX-1:0];
    assign wr_tag   = pc_q[29:IDX];
    assign lk_idx   = pc[IDX+1:2];
    assign lk_tag   = pc[31:IDX+2];
    assign lk_entry = table_q[lk_idx];
    assign lk_hit   = valid_q[lk_idx] && (lk_entry.tag == lk_tag);

    // Write-sequence control and valid bits; the clear and word0/word1 addresses are disjoint.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            valid_q    <= '0;
            wr_pending <= 1'b0;
        end else if (wr_clear) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            wr_pending <= 1'b0;
        end else if (wr_word0) begin
            state_q    <= HAVE_PC;
            pc_q       <= sasa_data[31:2];
            wr_pending <= 1'b1;
        end else if (commit) begin
            state_q         <= IDLE;
            valid_q[wr_idx] <= sasa_data[16];
            wr_pending      <= 1'b0;
        end
    end

    // NOTE: the descriptor array has no reset; the valid bits alone decide whether an entry is live.
    always_ff @(posedge CLK) begin
        if (commit && !RST) begin
            table_q[wr_idx] <= '{tag:   wr_tag,
                                 rs1:   sasa_data[4:0],
                                 rs2:   sasa_data[9:5],
                                 insts: sasa_data[14:10],
                                 cond:  sasa_data[15]};
        end
    end

    // NOTE: non-blocking updates make the lookup read pre-write/pre-clear contents on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit   <= 1'b0;
            rs1   <= '0;
            rs2   <= '0;
            insts <= '0;
            cond  <= 1'b0;
        end else if (if_ex_enable) begin
            hit   <= lk_hit;
            rs1   <= lk_hit ? lk_entry.rs1   : 5'd0;
            rs2   <= lk_hit ? lk_entry.rs2   : 5'd0;
            insts <= lk_hit ? lk_entry.insts : 5'd0;
            cond  <= lk_hit && lk_entry.cond;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, pc[1:0], sasa_data[1:0], sasa_data[31:17]};

endmodule

// File: tb/tb_sparce_sasa_table.sv
// Scoreboard bench for sparce_sasa_table: a PC-keyed reference model predicts every
// registered output; a monitor compares each cycle's DUT response against the queue.
module tb_sparce_sasa_table;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        hit;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  insts;
    logic        cond;
    logic        wr_pending;

    sparce_sasa_table #(.SASA_ENTRIES(N), .SASA_ADDR(BASE)) dut (
        .CLK(clk), .RST(rst), .pc(pc), .if_ex_enable(en),
        .sasa_addr(addr), .sasa_data(data), .sasa_wen(wen),
        .hit(hit), .rs1(rs1), .rs2(rs2), .insts(insts), .cond(cond),
        .wr_pending(wr_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] insts;
        logic       cond;
        logic       wr_pending;
    } resp_t;

    typedef struct {
        bit          valid;
        logic [31:0] word;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  insts;
        logic        cond;
    } m_entry_t;

    m_entry_t    m_tab [N];
    bit          m_pending;
    logic [31:0] m_latched;
    resp_t       m_out;
    resp_t       exp_q [$];
    string       name_q [$];
    int          checks   = 0;
    int          failures = 0;
    string       phase    = "reset";

    task automatic check(input string name, input resp_t act, input resp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got hit=%0b rs1=%0d rs2=%0d insts=%0d cond=%0b pend=%0b, want hit=%0b rs1=%0d rs2=%0d insts=%0d cond=%0b pend=%0b",
                     name, act.hit, act.rs1, act.rs2, act.insts, act.cond, act.wr_pending,
                     exp.hit, exp.rs1, exp.rs2, exp.insts, exp.cond, exp.wr_pending);
        end
    endtask

    // Reference model: a PC is present when its slot ((pc/4) mod N) holds that same word address.
    task automatic model_step();
        int    idx;
        resp_t e;
        if (rst) begin
            foreach (m_tab[i]) m_tab[i].valid = 1'b0;
            m_pending = 1'b0;
            m_latched = '0;
            m_out     = '0;
        end else begin
            if (en) begin
                idx   = int'((pc >> 2) % N);
                m_out = '0;
                if (m_tab[idx].valid && m_tab[idx].word == (pc >> 2)) begin
                    m_out.hit   = 1'b1;
                    m_out.rs1   = m_tab[idx].rs1;
                    m_out.rs2   = m_tab[idx].rs2;
                    m_out.insts = m_tab[idx].insts;
                    m_out.cond  = m_tab[idx].cond;
                end
            end
            if (wen) begin
                if (addr == BASE + 32'd8) begin
                    foreach (m_tab[i]) m_tab[i].valid = 1'b0;
                    m_pending = 1'b0;
                end else if (addr == BASE) begin
                    m_latched = data >> 2;
                    m_pending = 1'b1;
                end else if (addr == BASE + 32'd4 && m_pending) begin
                    idx              = int'(m_latched % N);
                    m_tab[idx].valid = data[16];
                    m_tab[idx].word  = m_latched;
                    m_tab[idx].rs1   = data[4:0];
                    m_tab[idx].rs2   = data[9:5];
                    m_tab[idx].insts = data[14:10];
                    m_tab[idx].cond  = data[15];
                    m_pending        = 1'b0;
                end
            end
        end
        e            = m_out;
        e.wr_pending = m_pending;
        exp_q.push_back(e);
        name_q.push_back(phase);
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic e,
                         input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst  = r;
        pc   = p;
        en   = e;
        wen  = w;
        addr = a;
        data = d;
        model_step();
    endtask

    task automatic lookup(input logic [31:0] p);
        drive(1'b0, p, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p, input logic e);
        drive(1'b0, p, e, 1'b1, a, d);
    endtask

    // Monitor: every edge yields one registered response to compare against the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                resp_t act;
                act = '{hit, rs1, rs2, insts, cond, wr_pending};
                check(name_q.pop_front(), act, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] pcs [6];
        logic [31:0] r;
        pcs = '{32'h40, 32'h44, 32'h80, 32'h48, 32'hC0, 32'h104};
        rst = 1'b1; pc = '0; en = 1'b0; wen = 1'b0; addr = '0; data = '0;

        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        phase = "reset_clears_entries";
        wr(BASE, 32'h40, 32'h0, 1'b0);
        wr(BASE + 4, 32'h0001_7C41, 32'h0, 1'b0);
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h0);
        lookup(32'h40);

        phase = "basic_program";
        wr(BASE, 32'h40, 32'h0, 1'b1);
        wr(BASE + 4, 32'h0001_7C41, 32'h0, 1'b1);
        lookup(32'h40);
        lookup(32'h80);

        phase = "orphan_word1";
        wr(BASE + 4, 32'h0001_FFFF, 32'h0, 1'b1);
        lookup(32'h48);

        phase = "overwrite_latched_pc";
        wr(BASE + 8, 32'h0, 32'h0, 1'b1);
        wr(BASE, 32'h40, 32'h0, 1'b1);
        wr(BASE, 32'h44, 32'h0, 1'b1);
        wr(BASE + 4, 32'h0001_8C83, 32'h0, 1'b1);
        lookup(32'h44);
        lookup(32'h40);

        phase = "reset_mid_write";
        wr(BASE, 32'h48, 32'h0, 1'b1);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        wr(BASE + 4, 32'h0001_0421, 32'h0, 1'b1);
        lookup(32'h48);

        phase = "same_index_race";
        wr(BASE, 32'h40, 32'h0, 1'b1);
        wr(BASE + 4, 32'h0001_0003, 32'h40, 1'b1);
        lookup(32'h40);

        phase = "stall_hold";
        drive(1'b0, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        lookup(32'h80);

        phase = "clear_race_and_after";
        wr(BASE, 32'hC0, 32'h0, 1'b1);
        wr(BASE + 4, 32'h0001_83E7, 32'h0, 1'b1);
        lookup(32'hC0);
        wr(BASE + 8, 32'hDEAD_BEEF, 32'hC0, 1'b1);
        lookup(32'hC0);
        lookup(32'h40);
        wr(BASE + 4, 32'h0001_0001, 32'h0, 1'b1);
        lookup(32'h40);

        phase = "out_of_window";
        wr(BASE + 12, 32'h40, 32'h0, 1'b1);
        wr(BASE - 4, 32'h40, 32'h0, 1'b1);
        wr(BASE + 4, 32'h0001_0001, 32'h40, 1'b1);
        lookup(32'h40);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            logic        r_rst;
            logic        r_en;
            logic        r_wen;
            logic [31:0] r_addr;
            logic [31:0] r_data;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 99) < 2);
            r_en  = ($urandom_range(0, 99) < 80);
            r_wen = ($urandom_range(0, 99) < 45);
            r_pc  = ($urandom_range(0, 5) == 5) ? $urandom : pcs[$urandom_range(0, 5)];
            r     = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin r_addr = BASE;         r_data = pcs[$urandom_range(0, 5)] | {30'h0, r[1:0]}; end
                4, 5, 6, 7: begin r_addr = BASE + 32'd4; r_data = r | ((r[20:18] != 3'd0) ? 32'h1_0000 : 32'h0); end
                8:          begin r_addr = BASE + 32'd8; r_data = r; end
                default:    begin r_addr = BASE + 32'd12 + {r[3:0], 2'b00}; r_data = pcs[0]; end
            endcase
            drive(r_rst, r_pc, r_en, r_wen, r_addr, r_data);
        end

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        phase = "drain";
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            checks++;
            $display("FAIL drain: %0d responses still queued, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
